// File: rtl/mac_dot_seq.sv
// Sequences one MAC unit through an N-element dot product and holds the scalar result
// on a valid/ready output until the consumer takes it.
module mac_dot_seq #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 16,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  len,
  output logic                  busy,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a_data,
  input  logic [DATA_WIDTH-1:0] b_data,
  output logic [DATA_WIDTH-1:0] mac_b,
  output logic [DATA_WIDTH-1:0] mac_c,
  output logic                  mac_clear,
  output logic                  mac_output_signal,
  input  logic [ACC_WIDTH-1:0]  mac_result,
  output logic [ACC_WIDTH-1:0]  result,
  output logic                  out_valid,
  input  logic                  out_ready
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, HOLD} state_t;

  localparam logic [LEN_WIDTH-1:0] LEN_ONE = 1;

  state_t               state;
  state_t               state_next;
  logic [LEN_WIDTH-1:0] cnt;
  logic [LEN_WIDTH-1:0] len_q;
  logic                 beat;
  logic                 last_beat;

  assign beat      = (state == RUN) && in_valid;
  assign last_beat = beat && (cnt == (len_q - LEN_ONE));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A zero-length job skips RUN; DRAIN then reads the accumulator that IDLE just cleared.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (len != '0) ? RUN : DRAIN;
      RUN:     if (last_beat) state_next = DRAIN;
      DRAIN:   state_next = HOLD;
      HOLD:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy              = (state != IDLE);
    in_ready          = 1'b0;
    mac_clear         = 1'b1;
    mac_output_signal = 1'b0;
    mac_b             = '0;
    mac_c             = '0;
    out_valid         = 1'b0;
    case (state)
      RUN: begin
        mac_clear = 1'b0;
        in_ready  = 1'b1;
        // Stall cycles feed zeros so the accumulator adds nothing.
        if (in_valid) begin
          mac_b = a_data;
          mac_c = b_data;
        end
      end
      DRAIN: begin
        mac_clear         = 1'b0;
        mac_output_signal = 1'b1;
      end
      HOLD: begin
        out_valid = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      len_q  <= '0;
      result <= '0;
    end else begin
      if ((state == IDLE) && start && (len != '0)) begin
        len_q <= len;
        cnt   <= '0;
      end
      if (beat) begin
        cnt <= cnt + LEN_ONE;
      end
      if (state == DRAIN) begin
        result <= mac_result;
      end
    end
  end

endmodule

// File: tb/tb_mac_dot_seq.sv
// Directed bench for mac_dot_seq with a behavioural MAC and a result scoreboard.
module tb_mac_dot_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  len;
  logic        busy;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a_data;
  logic [7:0]  b_data;
  logic [7:0]  mac_b;
  logic [7:0]  mac_c;
  logic        mac_clear;
  logic        mac_output_signal;
  logic [15:0] mac_result;
  logic [15:0] result;
  logic        out_valid;
  logic        out_ready;

  logic [15:0] acc;
  logic [15:0] sb[$];
  int          checks = 0;
  int          errors = 0;
  int          beat_count = 0;
  int          beats_before;

  mac_dot_seq #(.DATA_WIDTH(8), .ACC_WIDTH(16), .LEN_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .a_data(a_data), .b_data(b_data),
    .mac_b(mac_b), .mac_c(mac_c), .mac_clear(mac_clear),
    .mac_output_signal(mac_output_signal), .mac_result(mac_result),
    .result(result), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // Behavioural MAC: accumulates every edge unless cleared, visible only while enabled.
  always @(posedge clk) begin
    if (mac_clear) acc <= '0;
    else           acc <= acc + mac_b * mac_c;
  end
  assign mac_result = mac_output_signal ? acc : 16'h0;

  always @(posedge clk) begin
    if (in_valid && in_ready) beat_count++;
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [7:0] n, input logic [15:0] expected);
    start = 1'b1;
    len   = n;
    sb.push_back(expected);
    step();
    start = 1'b0;
    len   = 8'd0;
  endtask

  task automatic feed(input logic [7:0] a, input logic [7:0] b, input int stalls);
    for (int i = 0; i < stalls; i++) begin
      in_valid = 1'b0;
      a_data   = 8'($urandom_range(1, 255));
      b_data   = 8'($urandom_range(1, 255));
      #1;
      check_output("stall_mac_b", 32'(mac_b), 0);
      check_output("stall_mac_c", 32'(mac_c), 0);
      step();
    end
    in_valid = 1'b1;
    a_data   = a;
    b_data   = b;
    #1;
    check_output("beat_in_ready", 32'(in_ready), 1);
    check_output("beat_mac_b", 32'(mac_b), 32'(a));
    check_output("beat_mac_c", 32'(mac_c), 32'(b));
    step();
    in_valid = 1'b0;
    a_data   = 8'd0;
    b_data   = 8'd0;
  endtask

  // Waits (bounded) for out_valid, then pops the scoreboard and compares the result.
  task automatic collect(input string tag);
    int          n = 0;
    logic [15:0] exp;
    while (out_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check_output({tag, "_timeout"}, 32'(n < 20), 1);
    check_output({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 1);
    exp = (sb.size() != 0) ? sb.pop_front() : 16'hdead;
    check_output({tag, "_result"}, 32'(result), 32'(exp));
  endtask

  task automatic finish_handshake(input string tag);
    out_ready = 1'b1;
    step();
    check_output({tag, "_out_valid_low"}, 32'(out_valid), 0);
    check_output({tag, "_idle"}, 32'(busy), 0);
  endtask

  initial begin
    logic [7:0] pa[3];
    logic [7:0] pb[3];
    pa = '{8'd5, 8'd4, 8'd6};
    pb = '{8'd3, 8'd2, 8'd3};

    reset = 1'b1; start = 1'b0; len = 8'd0; in_valid = 1'b0;
    a_data = 8'd0; b_data = 8'd0; out_ready = 1'b1;
    repeat (2) step();
    check_output("rst_busy", 32'(busy), 0);
    check_output("rst_in_ready", 32'(in_ready), 0);
    check_output("rst_out_valid", 32'(out_valid), 0);
    check_output("rst_mac_clear", 32'(mac_clear), 1);
    check_output("rst_mac_out", 32'(mac_output_signal), 0);
    check_output("rst_result", 32'(result), 0);
    reset = 1'b0;
    step();

    // Basic job: consecutive beats, result visible two edges after last beat.
    apply_stimulus(8'd3, 16'd41);
    check_output("basic_busy", 32'(busy), 1);
    for (int i = 0; i < 3; i++) feed(pa[i], pb[i], 0);
    check_output("basic_drain_mac_out", 32'(mac_output_signal), 1);
    check_output("basic_drain_in_ready", 32'(in_ready), 0);
    check_output("basic_drain_mac_clear", 32'(mac_clear), 0);
    step();
    check_output("basic_hold_out_valid", 32'(out_valid), 1);
    check_output("basic_hold_mac_out", 32'(mac_output_signal), 0);
    collect("basic");
    step();
    check_output("basic_out_valid_1cyc", 32'(out_valid), 0);
    check_output("basic_idle", 32'(busy), 0);

    // Stalls between beats must add nothing and accept exactly three beats.
    beats_before = beat_count;
    apply_stimulus(8'd3, 16'd41);
    for (int i = 0; i < 3; i++) feed(pa[i], pb[i], 2);
    collect("stall");
    check_output("stall_beats", 32'(beat_count - beats_before), 3);
    finish_handshake("stall");

    // Zero length goes straight to DRAIN without ever asserting in_ready.
    beats_before = beat_count;
    in_valid = 1'b1;
    apply_stimulus(8'd0, 16'd0);
    check_output("zero_drain", 32'(mac_output_signal), 1);
    check_output("zero_in_ready", 32'(in_ready), 0);
    step();
    in_valid = 1'b0;
    collect("zero");
    check_output("zero_beats", 32'(beat_count - beats_before), 0);
    finish_handshake("zero");

    // Backpressure with a start pulse while holding.
    out_ready = 1'b0;
    apply_stimulus(8'd3, 16'd41);
    for (int i = 0; i < 3; i++) feed(pa[i], pb[i], 0);
    collect("bp");
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      len   = 8'd3;
      check_output("bp_out_valid_held", 32'(out_valid), 1);
      check_output("bp_result_held", 32'(result), 41);
      step();
    end
    start = 1'b0;
    finish_handshake("bp");
    step();
    check_output("bp_start_not_queued", 32'(busy), 0);

    // Wrapping sum, then a back-to-back job to prove the accumulator was cleared.
    apply_stimulus(8'd2, 16'd64514);
    feed(8'd255, 8'd255, 0);
    feed(8'd255, 8'd255, 0);
    collect("wrap");
    finish_handshake("wrap");
    apply_stimulus(8'd1, 16'd63);
    feed(8'd7, 8'd9, 0);
    collect("b2b");
    finish_handshake("b2b");

    // Reset mid-run abandons the job.
    apply_stimulus(8'd3, 16'd41);
    feed(pa[0], pb[0], 0);
    in_valid = 1'b1;
    a_data   = 8'd9;
    b_data   = 8'd9;
    reset    = 1'b1;
    #1;
    check_output("midrst_busy", 32'(busy), 0);
    check_output("midrst_in_ready", 32'(in_ready), 0);
    check_output("midrst_mac_clear", 32'(mac_clear), 1);
    check_output("midrst_mac_b", 32'(mac_b), 0);
    check_output("midrst_result", 32'(result), 0);
    check_output("midrst_out_valid", 32'(out_valid), 0);
    sb.delete();
    in_valid = 1'b0;
    step();
    reset = 1'b0;
    step();
    apply_stimulus(8'd3, 16'd41);
    for (int i = 0; i < 3; i++) feed(pa[i], pb[i], 0);
    collect("after_rst");
    finish_handshake("after_rst");

    check_output("sb_drained", 32'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mac_dot_seq.md
Name: mac_dot_seq

Overview:
- Sequencer that drives one MAC unit through a complete dot product of length N, then returns the scalar result.
- Accepts operand pairs on a valid/ready stream and feeds them to the MAC one pair per beat.
- Clears the MAC accumulator between jobs, raises the MAC output enable to read the sum, and holds the result on a valid/ready output.
- Sits between the operand buffers and a MAC instance in the tensor array.

Parameters:
DATA_WIDTH, 8, operand width (matches MAC B/C)
ACC_WIDTH, 16, accumulator/result width (matches MAC result)
LEN_WIDTH, 8, width of vector-length field; max N = 2^LEN_WIDTH-1

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high; returns block to IDLE
start  in  1  job request; sampled only in IDLE
len  in  LEN_WIDTH  vector length N; captured when start accepted
busy  out  1  high in every state except IDLE
in_valid  in  1  operand pair valid
in_ready  out  1  block accepts operand pair
a_data  in  DATA_WIDTH  operand A
b_data  in  DATA_WIDTH  operand B
mac_b  out  DATA_WIDTH  to MAC B
mac_c  out  DATA_WIDTH  to MAC C
mac_clear  out  1  to MAC reset; clears accumulator
mac_output_signal  out  1  to MAC output_signal
mac_result  in  ACC_WIDTH  from MAC result
result  out  ACC_WIDTH  captured dot product
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result

Behaviour:
- MAC contract:
  - Accumulator adds mac_b*mac_c on every rising clk while mac_clear=0.
  - mac_clear=1 forces the accumulator to 0.
  - mac_result shows the accumulator register while mac_output_signal=1.
  - Sum wraps modulo 2^ACC_WIDTH. The block performs no saturation.
- States: IDLE, RUN, DRAIN, HOLD.
- Reset (async) forces:
  - state=IDLE, cnt=0, len_q=0, result=0.
  - out_valid=0, in_ready=0, busy=0.
  - mac_clear=1, mac_output_signal=0, mac_b=mac_c=0.
- IDLE:
  - mac_clear=1.
  - If start=1 and len!=0, capture len_q=len, cnt=0, then go to RUN.
  - If start=1 and len==0, go to DRAIN.
  - start in any other state is ignored (not queued).
- RUN:
  - mac_clear=0, in_ready=1, mac_output_signal=0.
  - A beat occurs when in_valid=1. On a beat, mac_b=a_data and mac_c=b_data combinationally, and cnt increments.
  - When there is no beat, mac_b=mac_c=0, so the stall adds 0.
  - A beat with cnt==len_q-1 goes to DRAIN.
  - Exactly N beats are accepted. in_ready drops the cycle after the last beat.
- DRAIN (1 cycle):
  - mac_clear=0, mac_b=mac_c=0, mac_output_signal=1.
  - result<=mac_result at the end of the cycle, then go to HOLD.
  - Sum becomes visible one cycle after the last beat, so beat-to-result latency is 2 cycles minimum (last beat edge, then DRAIN capture edge).
- HOLD:
  - out_valid=1, result stable, mac_clear=1, mac_output_signal=0.
  - When out_ready=1, go to IDLE. out_valid is low the next cycle.
  - out_ready is allowed to be high before out_valid.
- mac_output_signal is high only in DRAIN.
- mac_b and mac_c are nonzero only on RUN beats.
- Reset mid-operation abandons the job. No partial result is produced, and the accumulator is cleared via mac_clear=1.
- cnt width is LEN_WIDTH. cnt never wraps because the exit condition is cnt==len_q-1.
- len, a_data and b_data are unsigned.

Test Plan:
- Basic job:
  - Stimulus: start, len=3; pairs (5,3),(4,2),(6,3) on consecutive cycles, in_valid=1, out_ready=1.
  - Required: mac_output_signal pulses 1 cycle after the third beat; result=41; out_valid for 1 cycle; back to IDLE.
- Stalls:
  - Stimulus: same pairs with in_valid low for 2 cycles between each pair.
  - Required: mac_b=mac_c=0 during stalls; result=41; exactly 3 beats accepted.
- Zero length:
  - Stimulus: start with len=0.
  - Required: no in_ready; DRAIN then HOLD; result=0.
- Backpressure and start ignored:
  - Stimulus: out_ready=0 for 5 cycles after result; start pulsed while in HOLD.
  - Required: out_valid and result=41 held steady; extra start ignored; IDLE after out_ready.
- Wrap and back-to-back jobs:
  - Stimulus: len=2 with (255,255) twice; then a second job, len=1, (7,9).
  - Required: first result=64514 (130050 mod 65536); second result=63, proving the accumulator was cleared.
- Reset mid-run:
  - Stimulus: assert reset after 1 beat of a len=3 job; release; run the basic job.
  - Required: all outputs at reset values immediately; next job result=41.
